// File: rtl/adv_game_pkg.sv
// adv_game_pkg: shared definitions for the adventure-game session controller.
//   - state_t      : controller FSM states (RST .. OVER)
//   - DIR_*        : bit positions inside the {n,s,e,w} direction mask
//   - DEF_*        : default parameter values used by the modules
//   - WAIT_W       : width of the internal reset/settle wait counter
package adv_game_pkg;

  typedef enum logic [2:0] {
    RST    = 3'd0,
    IDLE   = 3'd1,
    ISSUE  = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam int DIR_N = 3;
  localparam int DIR_S = 2;
  localparam int DIR_E = 1;
  localparam int DIR_W = 0;

  localparam int DEF_MOVE_W        = 8;
  localparam int DEF_MAX_MOVES     = 200;
  localparam int DEF_RST_CYCLES    = 2;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Wide enough for any sensible RST_CYCLES / SETTLE_CYCLES setting.
  localparam int WAIT_W = 16;

endpackage

// File: rtl/adv_move_counter.sv
// adv_move_counter: saturating move counter with clear and limit compare.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   clr         : clear count to zero (has priority over inc)
//   inc         : add one, saturating at 2^MOVE_W-1
//   count       : current count
//   at_limit    : count >= MAX_MOVES (always 0 when MAX_MOVES == 0)
module adv_move_counter
  import adv_game_pkg::*;
#(
  parameter int MOVE_W    = DEF_MOVE_W,
  parameter int MAX_MOVES = DEF_MAX_MOVES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [MOVE_W-1:0] count,
  output logic              at_limit
);

  localparam logic [MOVE_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]       LIMIT   = 32'(MAX_MOVES);

  logic [MOVE_W-1:0] count_reg, count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count    = count_reg;
  // Compare at 32 bits so a limit above the counter range never matches.
  assign at_limit = (MAX_MOVES != 0) && (32'(count_reg) >= LIMIT);

endmodule

// File: rtl/adv_game_ctrl.sv
// adv_game_ctrl: session controller sitting between the command front end
// and the room-maze FSM. Accepts commands (valid/ready), issues one-cycle
// direction pulses, waits for the maze to settle, samples win/dead, tracks
// the sword and latches the game outcome.
// Configuration macro: ADV_MOVE_LIMIT_EN enables the MAX_MOVES timeout.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake
//   cmd_dir[3:0] {n,s,e,w}         : direction mask, cmd_new : new game
//   room_n/s/e/w, room_v, room_reset : drives to the room FSM
//   room_sw, room_win, room_dead   : status from the room FSM
//   has_sword, move_count          : game progress
//   game_over/won/dead/timeout     : latched outcome
module adv_game_ctrl
  import adv_game_pkg::*;
#(
  parameter int MOVE_W        = DEF_MOVE_W,
  parameter int MAX_MOVES     = DEF_MAX_MOVES,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_dir,
  input  logic              cmd_new,
  output logic              room_n,
  output logic              room_s,
  output logic              room_e,
  output logic              room_w,
  output logic              room_v,
  output logic              room_reset,
  input  logic              room_sw,
  input  logic              room_win,
  input  logic              room_dead,
  output logic              has_sword,
  output logic [MOVE_W-1:0] move_count,
  output logic              game_over,
  output logic              game_won,
  output logic              game_dead,
  output logic              game_timeout
);

  localparam logic [WAIT_W-1:0] RST_LAST    = WAIT_W'(RST_CYCLES - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 2);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [3:0]        mask_reg, mask_next;
  logic              won_reg, won_next;
  logic              dead_reg, dead_next;
  logic              over_reg, over_next;
  logic              sword_reg;
  logic              cnt_clr, cnt_inc, at_limit;
  logic              handshake;
  logic [3:0]        pulse;
`ifdef ADV_MOVE_LIMIT_EN
  logic              timeout_reg, timeout_next;
`else
  logic              unused_limit;
  assign unused_limit = at_limit;
`endif

  adv_move_counter #(
    .MOVE_W    (MOVE_W),
    .MAX_MOVES (MAX_MOVES)
  ) u_moves (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .count    (move_count),
    .at_limit (at_limit)
  );

  // Gated with reset so the outputs are quiet even before the first edge.
  assign cmd_ready  = ~reset & ((state_reg == IDLE) | (state_reg == OVER));
  assign handshake  = cmd_valid & cmd_ready;
  assign room_reset = reset | (state_reg == RST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pulse
      assign pulse[gi] = ~reset & (state_reg == ISSUE) & mask_reg[gi];
    end
  endgenerate

  assign room_n = pulse[DIR_N];
  assign room_s = pulse[DIR_S];
  assign room_e = pulse[DIR_E];
  assign room_w = pulse[DIR_W];

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    mask_next  = mask_reg;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    won_next   = won_reg;
    dead_next  = dead_reg;
    over_next  = over_reg;
`ifdef ADV_MOVE_LIMIT_EN
    timeout_next = timeout_reg;
`endif
    case (state_reg)
      RST: begin
        cnt_clr   = 1'b1;
        won_next  = 1'b0;
        dead_next = 1'b0;
        over_next = 1'b0;
`ifdef ADV_MOVE_LIMIT_EN
        timeout_next = 1'b0;
`endif
        if (wait_reg == RST_LAST) begin
          state_next = IDLE;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      IDLE: begin
        if (handshake) begin
          if (cmd_new) begin
            state_next = RST;
            wait_next  = '0;
          end else if (cmd_dir != 4'b0000) begin
            mask_next  = cmd_dir;
            cnt_inc    = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = SETTLE;
        wait_next  = '0;
      end
      SETTLE: begin
        if (wait_reg == SETTLE_LAST) begin
          state_next = CHECK;
        end else begin
          wait_next = wait_reg + 1'b1;
        end
      end
      CHECK: begin
        if (room_win) begin
          won_next   = 1'b1;
          over_next  = 1'b1;
          state_next = OVER;
        end else if (room_dead) begin
          dead_next  = 1'b1;
          over_next  = 1'b1;
          state_next = OVER;
`ifdef ADV_MOVE_LIMIT_EN
        end else if (at_limit) begin
          timeout_next = 1'b1;
          over_next    = 1'b1;
          state_next   = OVER;
`endif
        end else begin
          state_next = IDLE;
        end
      end
      OVER: begin
        // Direction commands are accepted here but intentionally ignored.
        if (handshake && cmd_new) begin
          state_next = RST;
          wait_next  = '0;
        end
      end
      default: begin
        state_next = RST;
        wait_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RST;
      wait_reg  <= '0;
      mask_reg  <= '0;
      won_reg   <= 1'b0;
      dead_reg  <= 1'b0;
      over_reg  <= 1'b0;
      sword_reg <= 1'b0;
`ifdef ADV_MOVE_LIMIT_EN
      timeout_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      mask_reg  <= mask_next;
      won_reg   <= won_next;
      dead_reg  <= dead_next;
      over_reg  <= over_next;
      // Sword is sticky for the whole game; only a new game clears it.
      if (state_reg == RST) begin
        sword_reg <= 1'b0;
      end else if (room_sw) begin
        sword_reg <= 1'b1;
      end
`ifdef ADV_MOVE_LIMIT_EN
      timeout_reg <= timeout_next;
`endif
    end
  end

  assign has_sword = sword_reg;
  assign room_v    = sword_reg;
  assign game_over = over_reg;
  assign game_won  = won_reg;
  assign game_dead = dead_reg;
`ifdef ADV_MOVE_LIMIT_EN
  assign game_timeout = timeout_reg;
`else
  assign game_timeout = 1'b0;
`endif

endmodule

// File: doc/adv_game_ctrl.md
Name: adv_game_ctrl

Overview:
- Session controller that sequences the room-maze FSM: accepts player commands over a valid/ready handshake, issues one-cycle direction pulses, waits for the maze to settle, then samples win/dead/sword status.
- Owns maze reset, tracks sword possession (drives the vorpal-sword input), counts moves and latches the game outcome.
- Sits between the input/command front end and the room FSM.

Parameters:
MOVE_W, 8, width of move counter
MAX_MOVES, 200, move limit (used only with ADV_MOVE_LIMIT_EN); 0 = unlimited
RST_CYCLES, 2, cycles room_reset is held per new game (>=1)
SETTLE_CYCLES, 2, cycles between direction pulse and status sample (>=2; room-4 outcome needs one extra edge)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  controller can accept command
cmd_dir  in  4  direction mask {n,s,e,w}; multi-bit masks passed through unchanged
cmd_new  in  1  new-game request (overrides cmd_dir)
room_n, room_s, room_e, room_w  out  1 each  direction pulses to room FSM
room_v  out  1  sword-held input to room FSM
room_reset  out  1  reset to room FSM
room_sw  in  1  maze in sword room
room_win  in  1  maze win state
room_dead  in  1  maze death state
has_sword  out  1  sword collected this game
move_count  out  MOVE_W  accepted direction commands this game
game_over  out  1  outcome latched
game_won  out  1  outcome = win
game_dead  out  1  outcome = death
game_timeout  out  1  outcome = move limit (0 when macro absent)

Behaviour:
- One clock (clk); reset is synchronous and active-high, port named reset.
- While reset is high: state=RST. room_reset=1 (combinational: reset | state==RST). cmd_ready=0, direction pulses=0, room_v=0, has_sword=0, move_count=0. game_over, game_won, game_dead and game_timeout are all 0. A reset asserted mid-operation aborts any state to the same values.
- States: RST, IDLE, ISSUE, SETTLE, CHECK, OVER.
- RST: room_reset=1 for RST_CYCLES cycles, then IDLE. Entered from reset or cmd_new. Clears has_sword, move_count and outcome flags.
- IDLE: cmd_ready=1. On handshake:
  - cmd_new=1 -> RST.
  - Otherwise, cmd_dir!=0 -> latch mask, move_count+1 (saturating at 2^MOVE_W-1), go to ISSUE.
  - Otherwise, cmd_dir==0 is consumed as a NOP; stay in IDLE.
- ISSUE: room_n/s/e/w = latched mask for exactly 1 cycle; cmd_ready=0; then SETTLE.
- SETTLE: all pulses 0; wait SETTLE_CYCLES-1 cycles, then CHECK.
- CHECK (1 cycle) samples room status:
  - room_win -> OVER, game_won=1.
  - Else room_dead -> OVER, game_dead=1.
  - Else the move-limit check (see Optional Feature).
  - Else IDLE.
  - Win has priority over dead if both are high.
- OVER: game_over=1; flags hold. cmd_ready=1 but only cmd_new is acted on; direction commands are consumed and dropped with move_count unchanged.
- Latency: handshake at cycle T -> pulse at T+1 -> CHECK at T+1+SETTLE_CYCLES -> cmd_ready again at T+2+SETTLE_CYCLES.
- has_sword is set on any cycle room_sw=1 outside RST and is sticky until the next RST. room_v = has_sword (registered).
- A simultaneous cmd_new and cmd_dir has cmd_new win.

Optional Feature:
- Macro ADV_MOVE_LIMIT_EN.
- Defined: in CHECK, if there is no win/dead, MAX_MOVES!=0 and move_count>=MAX_MOVES, go to OVER with game_timeout=1.
- Undefined: no limit logic; game_timeout is tied to 0; MAX_MOVES is ignored.

Decomposition:
- Package adv_game_pkg: state enum (RST..OVER), direction bit indices (DIR_N=3, DIR_S=2, DIR_E=1, DIR_W=0), default parameter constants.
- One natural sub-module, adv_move_counter: saturating counter with clear, increment, and limit-compare output.

Test Plan:
- Reset held 3 cycles, then released -> room_reset high for RST_CYCLES=2 more cycles; cmd_ready=0 until IDLE; all outcome flags 0; move_count=0.
- Commands E, S, W with maze stub asserting room_sw after W -> exactly one pulse per command 1 cycle after handshake; move_count=3; has_sword=1; room_v=1 from the following cycle.
- Mask {s,e}=4'b0110 with stub entering room 4 with sword, room_win asserted 2 cycles later -> game_won=1, game_over=1; subsequent E command is dropped and move_count is unchanged.
- Same path without sword, stub asserts room_dead -> game_dead=1, game_won=0; then cmd_new -> RST for 2 cycles and all flags cleared.
- With ADV_MOVE_LIMIT_EN, MAX_MOVES=3, four NOP-room moves -> game_timeout=1 after 3rd CHECK. Without the macro -> never times out, move_count=4.
- Reset asserted during SETTLE -> pulses 0 and room_reset=1 that cycle; state RST; no CHECK occurs.
